// File: rtl/vanilla_exe_bubble_classifier_pkg.sv
// Shared types for the EXE bubble classifier: bubble causes, long-op tags and
// the pipeline register layouts it observes.
package vanilla_exe_bubble_classifier_pkg;

   localparam int RV32_reg_addr_width_gp = 5;
   localparam int RV32_reg_els_gp        = 32;

   typedef enum logic [4:0] {
      e_exe_no_bubble,
      e_exe_bubble_branch_miss,
      e_exe_bubble_jalr_miss,
      e_exe_bubble_icache_miss,
      e_exe_bubble_stall_depend_dram,
      e_exe_bubble_stall_depend_seq_dram,
      e_exe_bubble_stall_depend_dram_amo,
      e_exe_bubble_stall_depend_global,
      e_exe_bubble_stall_depend_group,
      e_exe_bubble_stall_depend_fdiv,
      e_exe_bubble_stall_depend_idiv,
      e_exe_bubble_stall_depend_local_load,
      e_exe_bubble_stall_depend_imul,
      e_exe_bubble_stall_amo_aq,
      e_exe_bubble_stall_amo_rl,
      e_exe_bubble_stall_bypass,
      e_exe_bubble_stall_lr_aq,
      e_exe_bubble_stall_fence,
      e_exe_bubble_stall_remote_req,
      e_exe_bubble_stall_remote_credit,
      e_exe_bubble_stall_fdiv_busy,
      e_exe_bubble_stall_idiv_busy,
      e_exe_bubble_stall_fcsr,
      e_exe_bubble_stall_barrier
   } exe_bubble_type_e;

   typedef enum logic [2:0] {
      e_tag_none,
      e_tag_dram,
      e_tag_seq_dram,
      e_tag_dram_amo,
      e_tag_global,
      e_tag_group,
      e_tag_fdiv,
      e_tag_idiv
   } long_op_tag_e;

   typedef struct packed {
      logic write_rd;
      logic write_frd;
      logic read_rs1;
      logic read_rs2;
      logic read_frs1;
      logic read_frs2;
      logic is_load_op;
      logic is_amo_op;
      logic is_idiv_op;
      logic is_fdiv_op;
      logic is_fsqrt_op;
   } decode_s;

   typedef struct packed {
      logic [31:0] instruction;
      decode_s     decode;
      logic        icache_miss;
   } id_signals_s;

   typedef struct packed {
      logic [31:0] instruction;
      decode_s     decode;
      logic        icache_miss;
   } exe_signals_s;

   typedef struct packed {
      logic [4:0] fp_op;
      logic [2:0] rm;
      logic       fp_valid;
   } fp_exe_ctrl_s;

   // Higher rank means the dependency is blamed first when several operands are tagged.
   function automatic logic [2:0] tag_rank(input long_op_tag_e tag);
      case (tag)
         e_tag_fdiv:     return 3'd7;
         e_tag_idiv:     return 3'd6;
         e_tag_dram_amo: return 3'd5;
         e_tag_seq_dram: return 3'd4;
         e_tag_dram:     return 3'd3;
         e_tag_global:   return 3'd2;
         e_tag_group:    return 3'd1;
         default:        return 3'd0;
      endcase
   endfunction

   function automatic long_op_tag_e worst_tag(input long_op_tag_e a, input long_op_tag_e b);
      return (tag_rank(a) >= tag_rank(b)) ? a : b;
   endfunction

   // An untagged long-op dependency is most likely an in-flight DRAM access.
   function automatic exe_bubble_type_e depend_bubble(input long_op_tag_e tag);
      case (tag)
         e_tag_fdiv:     return e_exe_bubble_stall_depend_fdiv;
         e_tag_idiv:     return e_exe_bubble_stall_depend_idiv;
         e_tag_dram_amo: return e_exe_bubble_stall_depend_dram_amo;
         e_tag_seq_dram: return e_exe_bubble_stall_depend_seq_dram;
         e_tag_global:   return e_exe_bubble_stall_depend_global;
         e_tag_group:    return e_exe_bubble_stall_depend_group;
         default:        return e_exe_bubble_stall_depend_dram;
      endcase
   endfunction

endpackage

// File: rtl/vanilla_exe_bubble_classifier.sv
// Profiling monitor: classifies each EXE bubble by cause and charges it to a PC,
// and flags sequential DRAM loads entering EXE. Drives nothing in the core.
module vanilla_exe_bubble_classifier
   import vanilla_exe_bubble_classifier_pkg::*;
#(
   parameter int pc_width_p   = 22,
   parameter int data_width_p = 32
) (
   input  logic                    clk_i,
   input  logic                    reset_i,

   input  logic [data_width_p-1:0] id_pc,
   input  logic [data_width_p-1:0] exe_pc,
   input  id_signals_s             id_r,
   input  exe_signals_s            exe_r,
   input  fp_exe_ctrl_s            fp_exe_ctrl_r,

   input  logic                    flush,
   input  logic                    branch_mispredict,
   input  logic                    jalr_mispredict,
   input  logic                    icache_miss,
   input  logic                    icache_miss_in_pipe,

   input  logic                    stall_all,
   input  logic                    stall_id,
   input  logic                    stall_depend_long_op,
   input  logic                    stall_depend_local_load,
   input  logic                    stall_depend_imul,
   input  logic                    stall_bypass,
   input  logic                    stall_lr_aq,
   input  logic                    stall_fence,
   input  logic                    stall_amo_aq,
   input  logic                    stall_amo_rl,
   input  logic                    stall_fdiv_busy,
   input  logic                    stall_idiv_busy,
   input  logic                    stall_fcsr,
   input  logic                    stall_remote_req,
   input  logic                    stall_remote_credit,
   input  logic                    stall_barrier,

   input  logic [data_width_p-1:0] rs1_val_to_exe,
   input  logic [11:0]             mem_addr_op2,

   input  logic                    int_sb_clear,
   input  logic                    float_sb_clear,
   input  logic [RV32_reg_addr_width_gp-1:0] int_sb_clear_id,
   input  logic [RV32_reg_addr_width_gp-1:0] float_sb_clear_id,

   output logic [pc_width_p-1:0]   exe_bubble_pc_o,
   output exe_bubble_type_e        exe_bubble_type_o,
   output logic                    is_exe_seq_lw_o,
   output logic                    is_exe_seq_flw_o
);

   exe_bubble_type_e               bubble_type_r, bubble_type_n;
   logic [pc_width_p-1:0]          bubble_pc_r, bubble_pc_n;
   logic                           seq_lw_r, seq_lw_n;
   logic                           seq_flw_r, seq_flw_n;
   logic [data_width_p-1:0]        last_dram_addr_r, last_dram_addr_n;

   long_op_tag_e                   int_tag_r [RV32_reg_els_gp];
   long_op_tag_e                   fp_tag_r  [RV32_reg_els_gp];

   logic [RV32_reg_addr_width_gp-1:0] id_rs1, id_rs2, id_rd;
   logic                           issue;
   logic [data_width_p-1:0]        mem_addr;
   logic                           is_remote_load, is_dram_load, is_seq_dram;
   long_op_tag_e                   issue_tag;
   logic                           int_tag_we, fp_tag_we;
   long_op_tag_e                   rs1_tag, rs2_tag, rd_tag, dep_tag;
   logic                           stall_reason_any;
   logic                           unused_signals;

   assign id_rs1 = id_r.instruction[19:15];
   assign id_rs2 = id_r.instruction[24:20];
   assign id_rd  = id_r.instruction[11:7];
   assign issue  = ~stall_all & ~stall_id & ~flush;

   assign unused_signals = ^{exe_r, fp_exe_ctrl_r, icache_miss, icache_miss_in_pipe,
                             id_pc, exe_pc, id_r, mem_addr};

   // Effective address and long-op tag of the instruction leaving ID.
   always_comb begin
      mem_addr       = rs1_val_to_exe + {{(data_width_p-12){mem_addr_op2[11]}}, mem_addr_op2};
      is_remote_load = id_r.decode.is_load_op & ~id_r.decode.is_amo_op;
      is_dram_load   = is_remote_load & mem_addr[31];
      is_seq_dram    = is_dram_load & (mem_addr == (last_dram_addr_r + data_width_p'(4)));

      issue_tag = e_tag_none;
      if (id_r.decode.is_amo_op) begin
         issue_tag = e_tag_dram_amo;
      end else if (id_r.decode.is_idiv_op) begin
         issue_tag = e_tag_idiv;
      end else if (id_r.decode.is_fdiv_op | id_r.decode.is_fsqrt_op) begin
         issue_tag = e_tag_fdiv;
      end else if (is_remote_load) begin
         if (mem_addr[31])
            issue_tag = is_seq_dram ? e_tag_seq_dram : e_tag_dram;
         else if (mem_addr[31:30] == 2'b01)
            issue_tag = e_tag_global;
         else if (mem_addr[31:29] == 3'b001)
            issue_tag = e_tag_group;
      end
   end

   always_comb begin
      int_tag_we       = issue & id_r.decode.write_rd & (id_rd != '0) & (issue_tag != e_tag_none);
      fp_tag_we        = issue & id_r.decode.write_frd & (issue_tag != e_tag_none);
      seq_lw_n         = issue & id_r.decode.write_rd  & (issue_tag == e_tag_seq_dram);
      seq_flw_n        = issue & id_r.decode.write_frd & (issue_tag == e_tag_seq_dram);
      last_dram_addr_n = (issue & is_dram_load) ? mem_addr : last_dram_addr_r;
   end

   // Worst outstanding long op among the operands the stalled ID instruction touches.
   always_comb begin
      rs1_tag = e_tag_none;
      rs2_tag = e_tag_none;
      rd_tag  = e_tag_none;
      if (id_r.decode.read_rs1)
         rs1_tag = int_tag_r[id_rs1];
      else if (id_r.decode.read_frs1)
         rs1_tag = fp_tag_r[id_rs1];
      if (id_r.decode.read_rs2)
         rs2_tag = int_tag_r[id_rs2];
      else if (id_r.decode.read_frs2)
         rs2_tag = fp_tag_r[id_rs2];
      if (id_r.decode.write_rd)
         rd_tag = int_tag_r[id_rd];
      else if (id_r.decode.write_frd)
         rd_tag = fp_tag_r[id_rd];
      dep_tag = worst_tag(worst_tag(rs1_tag, rs2_tag), rd_tag);
   end

   assign stall_reason_any = stall_depend_long_op | stall_depend_local_load | stall_depend_imul
                           | stall_amo_aq | stall_amo_rl | stall_bypass | stall_lr_aq
                           | stall_fence | stall_remote_req | stall_remote_credit
                           | stall_fdiv_busy | stall_idiv_busy | stall_fcsr | stall_barrier;

   always_comb begin
      bubble_type_n = e_exe_no_bubble;
      bubble_pc_n   = '0;
      if (flush & branch_mispredict) begin
         bubble_type_n = e_exe_bubble_branch_miss;
         bubble_pc_n   = exe_pc[pc_width_p+1:2];
      end else if (flush & jalr_mispredict) begin
         bubble_type_n = e_exe_bubble_jalr_miss;
         bubble_pc_n   = exe_pc[pc_width_p+1:2];
      end else if (stall_id & stall_reason_any) begin
         bubble_pc_n = id_pc[pc_width_p+1:2];
         if (stall_depend_long_op)         bubble_type_n = depend_bubble(dep_tag);
         else if (stall_depend_local_load) bubble_type_n = e_exe_bubble_stall_depend_local_load;
         else if (stall_depend_imul)       bubble_type_n = e_exe_bubble_stall_depend_imul;
         else if (stall_amo_aq)            bubble_type_n = e_exe_bubble_stall_amo_aq;
         else if (stall_amo_rl)            bubble_type_n = e_exe_bubble_stall_amo_rl;
         else if (stall_bypass)            bubble_type_n = e_exe_bubble_stall_bypass;
         else if (stall_lr_aq)             bubble_type_n = e_exe_bubble_stall_lr_aq;
         else if (stall_fence)             bubble_type_n = e_exe_bubble_stall_fence;
         else if (stall_remote_req)        bubble_type_n = e_exe_bubble_stall_remote_req;
         else if (stall_remote_credit)     bubble_type_n = e_exe_bubble_stall_remote_credit;
         else if (stall_fdiv_busy)         bubble_type_n = e_exe_bubble_stall_fdiv_busy;
         else if (stall_idiv_busy)         bubble_type_n = e_exe_bubble_stall_idiv_busy;
         else if (stall_fcsr)              bubble_type_n = e_exe_bubble_stall_fcsr;
         else                              bubble_type_n = e_exe_bubble_stall_barrier;
      end else if (id_r.icache_miss) begin
         bubble_type_n = e_exe_bubble_icache_miss;
         bubble_pc_n   = id_pc[pc_width_p+1:2];
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         bubble_type_r    <= e_exe_no_bubble;
         bubble_pc_r      <= '0;
         seq_lw_r         <= 1'b0;
         seq_flw_r        <= 1'b0;
         last_dram_addr_r <= '0;
      end else if (!stall_all) begin
         bubble_type_r    <= bubble_type_n;
         bubble_pc_r      <= bubble_pc_n;
         seq_lw_r         <= seq_lw_n;
         seq_flw_r        <= seq_flw_n;
         last_dram_addr_r <= last_dram_addr_n;
      end
   end

   // The set is written after the clear so a same-cycle set of the same entry wins.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < RV32_reg_els_gp; i++) begin
            int_tag_r[i] <= e_tag_none;
            fp_tag_r[i]  <= e_tag_none;
         end
      end else if (!stall_all) begin
         if (int_sb_clear)
            int_tag_r[int_sb_clear_id] <= e_tag_none;
         if (float_sb_clear)
            fp_tag_r[float_sb_clear_id] <= e_tag_none;
         if (int_tag_we)
            int_tag_r[id_rd] <= issue_tag;
         if (fp_tag_we)
            fp_tag_r[id_rd] <= issue_tag;
      end
   end

   assign exe_bubble_type_o = bubble_type_r;
   assign exe_bubble_pc_o   = bubble_pc_r;
   assign is_exe_seq_lw_o   = seq_lw_r;
   assign is_exe_seq_flw_o  = seq_flw_r;

endmodule

// File: tb/tb_vanilla_exe_bubble_classifier.sv
// Self-checking bench for vanilla_exe_bubble_classifier: a cycle model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_vanilla_exe_bubble_classifier;
   import vanilla_exe_bubble_classifier_pkg::*;

   localparam int pc_width_lp   = 22;
   localparam int data_width_lp = 32;

   logic clk_i, reset_i;
   logic [31:0] id_pc, exe_pc;
   id_signals_s  id_r;
   exe_signals_s exe_r;
   fp_exe_ctrl_s fp_exe_ctrl_r;
   logic flush, branch_mispredict, jalr_mispredict, icache_miss, icache_miss_in_pipe;
   logic stall_all, stall_id, stall_depend_long_op, stall_depend_local_load, stall_depend_imul;
   logic stall_bypass, stall_lr_aq, stall_fence, stall_amo_aq, stall_amo_rl, stall_fdiv_busy;
   logic stall_idiv_busy, stall_fcsr, stall_remote_req, stall_remote_credit, stall_barrier;
   logic [31:0] rs1_val_to_exe;
   logic [11:0] mem_addr_op2;
   logic int_sb_clear, float_sb_clear;
   logic [4:0] int_sb_clear_id, float_sb_clear_id;
   logic [pc_width_lp-1:0] exe_bubble_pc_o;
   exe_bubble_type_e exe_bubble_type_o;
   logic is_exe_seq_lw_o, is_exe_seq_flw_o;

   vanilla_exe_bubble_classifier #(.pc_width_p(pc_width_lp), .data_width_p(data_width_lp)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .id_pc(id_pc), .exe_pc(exe_pc), .id_r(id_r),
      .exe_r(exe_r), .fp_exe_ctrl_r(fp_exe_ctrl_r), .flush(flush),
      .branch_mispredict(branch_mispredict), .jalr_mispredict(jalr_mispredict),
      .icache_miss(icache_miss), .icache_miss_in_pipe(icache_miss_in_pipe),
      .stall_all(stall_all), .stall_id(stall_id), .stall_depend_long_op(stall_depend_long_op),
      .stall_depend_local_load(stall_depend_local_load), .stall_depend_imul(stall_depend_imul),
      .stall_bypass(stall_bypass), .stall_lr_aq(stall_lr_aq), .stall_fence(stall_fence),
      .stall_amo_aq(stall_amo_aq), .stall_amo_rl(stall_amo_rl), .stall_fdiv_busy(stall_fdiv_busy),
      .stall_idiv_busy(stall_idiv_busy), .stall_fcsr(stall_fcsr),
      .stall_remote_req(stall_remote_req), .stall_remote_credit(stall_remote_credit),
      .stall_barrier(stall_barrier), .rs1_val_to_exe(rs1_val_to_exe), .mem_addr_op2(mem_addr_op2),
      .int_sb_clear(int_sb_clear), .float_sb_clear(float_sb_clear),
      .int_sb_clear_id(int_sb_clear_id), .float_sb_clear_id(float_sb_clear_id),
      .exe_bubble_pc_o(exe_bubble_pc_o), .exe_bubble_type_o(exe_bubble_type_o),
      .is_exe_seq_lw_o(is_exe_seq_lw_o), .is_exe_seq_flw_o(is_exe_seq_flw_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   bit checks_on = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- reference model ----------------
   long_op_tag_e m_int_tag [32];
   long_op_tag_e m_fp_tag  [32];
   logic [31:0] m_last_dram;
   exe_bubble_type_e exp_type;
   logic [pc_width_lp-1:0] exp_pc;
   logic exp_lw, exp_flw;

   function automatic long_op_tag_e blame(input long_op_tag_e a, input long_op_tag_e b, input long_op_tag_e c);
      long_op_tag_e order [7] = '{e_tag_fdiv, e_tag_idiv, e_tag_dram_amo, e_tag_seq_dram,
                                  e_tag_dram, e_tag_global, e_tag_group};
      for (int k = 0; k < 7; k++)
         if (a == order[k] || b == order[k] || c == order[k]) return order[k];
      return e_tag_none;
   endfunction

   task automatic modelStep();
      exe_bubble_type_e reason_t [13] = '{e_exe_bubble_stall_depend_local_load,
         e_exe_bubble_stall_depend_imul, e_exe_bubble_stall_amo_aq, e_exe_bubble_stall_amo_rl,
         e_exe_bubble_stall_bypass, e_exe_bubble_stall_lr_aq, e_exe_bubble_stall_fence,
         e_exe_bubble_stall_remote_req, e_exe_bubble_stall_remote_credit,
         e_exe_bubble_stall_fdiv_busy, e_exe_bubble_stall_idiv_busy, e_exe_bubble_stall_fcsr,
         e_exe_bubble_stall_barrier};
      bit reason_v [13] = '{stall_depend_local_load, stall_depend_imul, stall_amo_aq,
         stall_amo_rl, stall_bypass, stall_lr_aq, stall_fence, stall_remote_req,
         stall_remote_credit, stall_fdiv_busy, stall_idiv_busy, stall_fcsr, stall_barrier};
      int rs1 = int'(id_r.instruction[19:15]);
      int rs2 = int'(id_r.instruction[24:20]);
      int rd  = int'(id_r.instruction[11:7]);
      long_op_tag_e t1, t2, t3, tag;
      logic [31:0] addr;
      bit issue, found, ld;

      t1 = id_r.decode.read_rs1 ? m_int_tag[rs1] : (id_r.decode.read_frs1 ? m_fp_tag[rs1] : e_tag_none);
      t2 = id_r.decode.read_rs2 ? m_int_tag[rs2] : (id_r.decode.read_frs2 ? m_fp_tag[rs2] : e_tag_none);
      t3 = id_r.decode.write_rd ? m_int_tag[rd]  : (id_r.decode.write_frd ? m_fp_tag[rd]  : e_tag_none);

      found = 1'b0;
      exp_type = e_exe_no_bubble;
      exp_pc = '0;
      if (flush && (branch_mispredict || jalr_mispredict)) begin
         exp_type = branch_mispredict ? e_exe_bubble_branch_miss : e_exe_bubble_jalr_miss;
         exp_pc = pc_width_lp'(exe_pc / 4);
         found = 1'b1;
      end else if (stall_id) begin
         if (stall_depend_long_op) begin
            case (blame(t1, t2, t3))
               e_tag_fdiv:     exp_type = e_exe_bubble_stall_depend_fdiv;
               e_tag_idiv:     exp_type = e_exe_bubble_stall_depend_idiv;
               e_tag_dram_amo: exp_type = e_exe_bubble_stall_depend_dram_amo;
               e_tag_seq_dram: exp_type = e_exe_bubble_stall_depend_seq_dram;
               e_tag_global:   exp_type = e_exe_bubble_stall_depend_global;
               e_tag_group:    exp_type = e_exe_bubble_stall_depend_group;
               default:        exp_type = e_exe_bubble_stall_depend_dram;
            endcase
            found = 1'b1;
         end else begin
            for (int k = 0; k < 13; k++)
               if (!found && reason_v[k]) begin
                  exp_type = reason_t[k];
                  found = 1'b1;
               end
         end
         if (found) exp_pc = pc_width_lp'(id_pc / 4);
      end
      if (!found && id_r.icache_miss) begin
         exp_type = e_exe_bubble_icache_miss;
         exp_pc = pc_width_lp'(id_pc / 4);
      end

      issue = !stall_id && !flush;
      addr = rs1_val_to_exe + 32'($signed(mem_addr_op2));
      ld = id_r.decode.is_load_op && !id_r.decode.is_amo_op;
      tag = e_tag_none;
      if (id_r.decode.is_amo_op) tag = e_tag_dram_amo;
      else if (id_r.decode.is_idiv_op) tag = e_tag_idiv;
      else if (id_r.decode.is_fdiv_op || id_r.decode.is_fsqrt_op) tag = e_tag_fdiv;
      else if (ld && addr >= 32'h8000_0000) tag = (addr == m_last_dram + 4) ? e_tag_seq_dram : e_tag_dram;
      else if (ld && addr >= 32'h4000_0000) tag = e_tag_global;
      else if (ld && addr >= 32'h2000_0000) tag = e_tag_group;

      exp_lw  = issue && id_r.decode.write_rd  && tag == e_tag_seq_dram;
      exp_flw = issue && id_r.decode.write_frd && tag == e_tag_seq_dram;
      if (int_sb_clear) m_int_tag[int_sb_clear_id] = e_tag_none;
      if (float_sb_clear) m_fp_tag[float_sb_clear_id] = e_tag_none;
      if (issue && tag != e_tag_none) begin
         if (id_r.decode.write_rd && rd != 0) m_int_tag[rd] = tag;
         if (id_r.decode.write_frd) m_fp_tag[rd] = tag;
      end
      if (issue && ld && addr[31]) m_last_dram = addr;
   endtask

   always @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < 32; i++) begin
            m_int_tag[i] = e_tag_none;
            m_fp_tag[i] = e_tag_none;
         end
         m_last_dram = '0;
         exp_type = e_exe_no_bubble;
         exp_pc = '0;
         exp_lw = 1'b0;
         exp_flw = 1'b0;
      end else if (!stall_all) begin
         modelStep();
      end
   end

   always @(negedge clk_i) begin
      if (checks_on) begin
         checkOutput("cmp_type", 32'(exe_bubble_type_o), 32'(exp_type));
         checkOutput("cmp_pc", 32'(exe_bubble_pc_o), 32'(exp_pc));
         checkOutput("cmp_seq_lw", 32'(is_exe_seq_lw_o), 32'(exp_lw));
         checkOutput("cmp_seq_flw", 32'(is_exe_seq_flw_o), 32'(exp_flw));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic setDefaults();
      id_pc = '0; exe_pc = '0; id_r = '0; exe_r = '0; fp_exe_ctrl_r = '0;
      flush = 0; branch_mispredict = 0; jalr_mispredict = 0; icache_miss = 0;
      icache_miss_in_pipe = 0; stall_all = 0; stall_id = 0; stall_depend_long_op = 0;
      stall_depend_local_load = 0; stall_depend_imul = 0; stall_bypass = 0; stall_lr_aq = 0;
      stall_fence = 0; stall_amo_aq = 0; stall_amo_rl = 0; stall_fdiv_busy = 0;
      stall_idiv_busy = 0; stall_fcsr = 0; stall_remote_req = 0; stall_remote_credit = 0;
      stall_barrier = 0; rs1_val_to_exe = '0; mem_addr_op2 = '0;
      int_sb_clear = 0; float_sb_clear = 0; int_sb_clear_id = '0; float_sb_clear_id = '0;
   endtask

   task automatic applyStimulus();
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      setDefaults();
   endtask

   task automatic loadOp(input logic [4:0] rd, input bit fp, input logic [31:0] base, input logic [11:0] imm);
      id_r.instruction = {20'h0, rd, 7'h03};
      id_r.decode.is_load_op = 1'b1;
      id_r.decode.read_rs1 = 1'b1;
      id_r.decode.write_rd = !fp;
      id_r.decode.write_frd = fp;
      rs1_val_to_exe = base;
      mem_addr_op2 = imm;
   endtask

   task automatic longOp(input logic [4:0] rd, input bit fp, input int kind);
      id_r.instruction = {20'h0, rd, 7'h33};
      id_r.decode.write_rd = !fp;
      id_r.decode.write_frd = fp;
      id_r.decode.is_amo_op = (kind == 0);
      id_r.decode.is_idiv_op = (kind == 1);
      id_r.decode.is_fdiv_op = (kind == 2);
   endtask

   task automatic dependStall(input logic [4:0] rs1, input bit fp1, input bit use2,
                              input logic [4:0] rs2, input bit fp2, input logic [31:0] pc);
      id_r.instruction = {7'h0, rs2, rs1, 3'h0, 5'h0, 7'h33};
      id_r.decode.read_rs1 = !fp1;
      id_r.decode.read_frs1 = fp1;
      id_r.decode.read_rs2 = use2 && !fp2;
      id_r.decode.read_frs2 = use2 && fp2;
      stall_id = 1'b1;
      stall_depend_long_op = 1'b1;
      id_pc = pc;
   endtask

   task automatic setReason(input int k);
      case (k)
         0: stall_depend_local_load = 1;  1: stall_depend_imul = 1;  2: stall_amo_aq = 1;
         3: stall_amo_rl = 1;             4: stall_bypass = 1;       5: stall_lr_aq = 1;
         6: stall_fence = 1;              7: stall_remote_req = 1;   8: stall_remote_credit = 1;
         9: stall_fdiv_busy = 1;         10: stall_idiv_busy = 1;   11: stall_fcsr = 1;
         default: stall_barrier = 1;
      endcase
   endtask

   task automatic expectLit(input string name, input exe_bubble_type_e t, input logic [31:0] pc);
      checkOutput({name, "_type"}, 32'(exe_bubble_type_o), 32'(t));
      checkOutput({name, "_pc"}, 32'(exe_bubble_pc_o), pc);
   endtask

   exe_bubble_type_e reason_lit [13] = '{e_exe_bubble_stall_depend_local_load,
      e_exe_bubble_stall_depend_imul, e_exe_bubble_stall_amo_aq, e_exe_bubble_stall_amo_rl,
      e_exe_bubble_stall_bypass, e_exe_bubble_stall_lr_aq, e_exe_bubble_stall_fence,
      e_exe_bubble_stall_remote_req, e_exe_bubble_stall_remote_credit,
      e_exe_bubble_stall_fdiv_busy, e_exe_bubble_stall_idiv_busy, e_exe_bubble_stall_fcsr,
      e_exe_bubble_stall_barrier};

   initial begin
      setDefaults();
      reset_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      expectLit("reset", e_exe_no_bubble, 32'h0);
      checkOutput("reset_seq_lw", 32'(is_exe_seq_lw_o), 32'h0);
      checkOutput("reset_seq_flw", 32'(is_exe_seq_flw_o), 32'h0);
      reset_i = 1'b1;
      checks_on = 1'b1;

      applyStimulus();
      applyStimulus();
      expectLit("idle", e_exe_no_bubble, 32'h0);

      flush = 1; branch_mispredict = 1; exe_pc = 32'h1000;
      applyStimulus();
      expectLit("branch", e_exe_bubble_branch_miss, 32'h400);
      flush = 1; jalr_mispredict = 1; exe_pc = 32'h2008;
      applyStimulus();
      expectLit("jalr", e_exe_bubble_jalr_miss, 32'h802);

      loadOp(5, 0, 32'h8000_0000, 12'h010);
      applyStimulus();
      checkOutput("lw_dram_not_seq", 32'(is_exe_seq_lw_o), 32'h0);
      dependStall(5, 0, 0, 0, 0, 32'h2004);
      applyStimulus();
      expectLit("dep_dram", e_exe_bubble_stall_depend_dram, 32'h801);
      int_sb_clear = 1; int_sb_clear_id = 5;
      applyStimulus();
      dependStall(5, 0, 0, 0, 0, 32'h2004);
      applyStimulus();
      expectLit("dep_cleared", e_exe_bubble_stall_depend_dram, 32'h801);

      loadOp(6, 0, 32'h4000_0000, 12'h000);
      applyStimulus();
      dependStall(6, 0, 0, 0, 0, 32'h2100);
      applyStimulus();
      expectLit("dep_global", e_exe_bubble_stall_depend_global, 32'h840);
      int_sb_clear = 1; int_sb_clear_id = 6;
      applyStimulus();
      dependStall(6, 0, 0, 0, 0, 32'h2100);
      applyStimulus();
      expectLit("no_stale_tag", e_exe_bubble_stall_depend_dram, 32'h840);

      loadOp(7, 0, 32'h8000_0000, 12'h010);
      applyStimulus();
      loadOp(3, 1, 32'h8000_0020, 12'hFF4);
      applyStimulus();
      checkOutput("flw_seq", 32'(is_exe_seq_flw_o), 32'h1);
      checkOutput("flw_not_lw", 32'(is_exe_seq_lw_o), 32'h0);
      dependStall(1, 0, 1, 3, 1, 32'h2200);
      applyStimulus();
      expectLit("dep_seq", e_exe_bubble_stall_depend_seq_dram, 32'h880);

      loadOp(8, 0, 32'h4000_0000, 12'h000);
      applyStimulus();
      loadOp(9, 0, 32'h2000_0000, 12'h000);
      applyStimulus();
      dependStall(8, 0, 1, 9, 0, 32'h2300);
      applyStimulus();
      expectLit("global_over_group", e_exe_bubble_stall_depend_global, 32'h8C0);
      dependStall(9, 0, 0, 0, 0, 32'h2300);
      applyStimulus();
      expectLit("dep_group", e_exe_bubble_stall_depend_group, 32'h8C0);

      loadOp(10, 0, 32'h8000_0018, 12'h000);
      applyStimulus();
      checkOutput("lw_seq", 32'(is_exe_seq_lw_o), 32'h1);
      longOp(11, 0, 1);
      applyStimulus();
      dependStall(10, 0, 1, 11, 0, 32'h2400);
      applyStimulus();
      expectLit("idiv_over_seq", e_exe_bubble_stall_depend_idiv, 32'h900);
      longOp(4, 1, 2);
      applyStimulus();
      dependStall(4, 1, 1, 11, 0, 32'h2404);
      applyStimulus();
      expectLit("fdiv_over_idiv", e_exe_bubble_stall_depend_fdiv, 32'h901);

      longOp(12, 0, 0);
      int_sb_clear = 1; int_sb_clear_id = 12;
      applyStimulus();
      dependStall(12, 0, 0, 0, 0, 32'h2500);
      applyStimulus();
      expectLit("set_wins", e_exe_bubble_stall_depend_dram_amo, 32'h940);

      loadOp(0, 0, 32'h4000_0000, 12'h000);
      applyStimulus();
      dependStall(0, 0, 1, 9, 0, 32'h2600);
      applyStimulus();
      expectLit("x0_untagged", e_exe_bubble_stall_depend_group, 32'h980);

      for (int k = 0; k < 13; k++) begin
         stall_id = 1; setReason(k); id_pc = 32'h100 + 32'(4 * k);
         applyStimulus();
         expectLit($sformatf("reason%0d", k), reason_lit[k], 32'h40 + 32'(k));
      end
      stall_id = 1; stall_bypass = 1; stall_fcsr = 1; id_pc = 32'h200;
      applyStimulus();
      expectLit("bypass_over_fcsr", e_exe_bubble_stall_bypass, 32'h80);
      stall_id = 1; stall_depend_long_op = 1; stall_fence = 1; id_pc = 32'h204;
      applyStimulus();
      expectLit("long_op_first", e_exe_bubble_stall_depend_dram, 32'h81);

      id_r.icache_miss = 1; id_pc = 32'h3010;
      applyStimulus();
      expectLit("icache", e_exe_bubble_icache_miss, 32'hC04);

      flush = 1; branch_mispredict = 1; exe_pc = 32'h3000;
      applyStimulus();
      for (int k = 0; k < 3; k++) begin
         stall_all = 1; stall_id = 1; stall_fence = 1; id_pc = 32'h4000;
         applyStimulus();
         expectLit($sformatf("frozen%0d", k), e_exe_bubble_branch_miss, 32'hC00);
      end
      stall_id = 1; stall_fence = 1; id_pc = 32'h4000;
      applyStimulus();
      expectLit("fence_release", e_exe_bubble_stall_fence, 32'h1000);

      applyStimulus();
      expectLit("final_idle", e_exe_no_bubble, 32'h0);

      checks_on = 1'b0;
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
